// File: rtl/camera_mc_pkg.sv
// camera_mc_pkg: register map, bit indices and config struct shared by the camera register interface
package camera_mc_pkg;

    localparam logic [4:0] ADDR_GLOB       = 5'd16;
    localparam logic [4:0] ADDR_LL         = 5'd17;
    localparam logic [4:0] ADDR_UR         = 5'd18;
    localparam logic [4:0] ADDR_SIZE       = 5'd19;
    localparam logic [4:0] ADDR_FILTER     = 5'd20;
    localparam logic [4:0] ADDR_POL        = 5'd21;
    localparam logic [4:0] ADDR_CTRL       = 5'd22;
    localparam logic [4:0] ADDR_IRQ_STATUS = 5'd23;
    localparam logic [4:0] ADDR_IRQ_EN     = 5'd24;

    localparam logic [1:0] RX_SADDR = 2'd0;
    localparam logic [1:0] RX_SIZE  = 2'd1;
    localparam logic [1:0] RX_CFG   = 2'd2;

    localparam int IRQ_FRAME_START = 0;
    localparam int IRQ_FRAME_END   = 1;
    localparam int IRQ_OVERFLOW    = 2;
    localparam int IRQ_COMMIT_DONE = 3;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_FORCE  = 1;

    typedef struct packed {
        logic [31:0] glob;
        logic [31:0] ll;
        logic [31:0] ur;
        logic [31:0] size;
        logic [31:0] filter;
    } cam_cfg_t;

endpackage

// File: rtl/camera_rx_ch_regs.sv
// camera_rx_ch_regs: one uDMA RX channel's registers, enable/clear pulses and read mux
module camera_rx_ch_regs
    import camera_mc_pkg::*;
#(
    parameter int AW = 12,
    parameter int TW = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          wr_i,
    input  logic [1:0]    reg_i,
    input  logic [31:0]   wdata_i,
    input  logic          en_i,
    input  logic          pending_i,
    input  logic [AW-1:0] curr_addr_i,
    input  logic [TW-1:0] bytes_left_i,
    output logic [AW-1:0] startaddr_o,
    output logic [TW-1:0] size_o,
    output logic [1:0]    datasize_o,
    output logic          continuous_o,
    output logic          en_o,
    output logic          clr_o,
    output logic [31:0]   rdata_o
);

    logic wr_cfg;
    logic unused_wdata;

    assign wr_cfg       = wr_i && (reg_i == RX_CFG);
    assign unused_wdata = ^wdata_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            startaddr_o  <= '0;
            size_o       <= '0;
            datasize_o   <= '0;
            continuous_o <= 1'b0;
            en_o         <= 1'b0;
            clr_o        <= 1'b0;
        end else begin
            en_o  <= wr_cfg && wdata_i[4];
            clr_o <= wr_cfg && wdata_i[6];
            if (wr_i && (reg_i == RX_SADDR))
                startaddr_o <= wdata_i[AW-1:0];
            if (wr_i && (reg_i == RX_SIZE))
                size_o <= wdata_i[TW-1:0];
            if (wr_cfg) begin
                datasize_o   <= wdata_i[2:1];
                continuous_o <= wdata_i[0];
            end
        end
    end

    always_comb
        rdata_o = (reg_i == RX_SADDR) ? 32'(curr_addr_i) :
                  (reg_i == RX_SIZE)  ? 32'(bytes_left_i) :
                  (reg_i == RX_CFG)   ? {26'h0, pending_i, en_i, 1'b0, datasize_o, continuous_o} :
                                        32'h0;

endmodule

// File: rtl/camera_reg_if_mc.sv
// camera_reg_if_mc: multi-channel uDMA camera register interface with frame-synchronised config commit
module camera_reg_if_mc
    import camera_mc_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int NUM_CH         = 2
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [31:0]                        cfg_data_i,
    input  logic [4:0]                         cfg_addr_i,
    input  logic                               cfg_valid_i,
    input  logic                               cfg_rwn_i,
    output logic [31:0]                        cfg_data_o,
    output logic                               cfg_ready_o,
    output logic [NUM_CH*L2_AWIDTH_NOAL-1:0]   cfg_rx_startaddr_o,
    output logic [NUM_CH*TRANS_SIZE-1:0]       cfg_rx_size_o,
    output logic [NUM_CH*2-1:0]                cfg_rx_datasize_o,
    output logic [NUM_CH-1:0]                  cfg_rx_continuous_o,
    output logic [NUM_CH-1:0]                  cfg_rx_en_o,
    output logic [NUM_CH-1:0]                  cfg_rx_clr_o,
    input  logic [NUM_CH-1:0]                  cfg_rx_en_i,
    input  logic [NUM_CH-1:0]                  cfg_rx_pending_i,
    input  logic [NUM_CH*L2_AWIDTH_NOAL-1:0]   cfg_rx_curr_addr_i,
    input  logic [NUM_CH*TRANS_SIZE-1:0]       cfg_rx_bytes_left_i,
    input  logic                               cam_frame_start_i,
    input  logic                               cam_frame_end_i,
    input  logic                               cam_overflow_i,
    input  logic                               cfg_cam_ip_en_i,
    output logic [31:0]                        cfg_cam_cfg_o,
    output logic [31:0]                        cfg_cam_cfg_ll_o,
    output logic [31:0]                        cfg_cam_cfg_ur_o,
    output logic [31:0]                        cfg_cam_cfg_size_o,
    output logic [31:0]                        cfg_cam_cfg_filter_o,
    output logic                               cfg_cam_vsync_polarity_o,
    output logic                               cfg_cam_hsync_polarity_o,
    output logic                               irq_o
);

    cam_cfg_t    stg, act;
    logic [1:0]  pol;
    logic [3:0]  irq_status, irq_en, status_nxt, status_set, status_clr;
    logic        commit_pending, ctrl_set, ctrl_force, do_copy, wr;
    logic [31:0] ch_rdata [NUM_CH];
    logic [31:0] rx_rdata;

    assign wr          = cfg_valid_i && !cfg_rwn_i;
    assign cfg_ready_o = 1'b1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        camera_rx_ch_regs #(
            .AW (L2_AWIDTH_NOAL),
            .TW (TRANS_SIZE)
        ) u_ch (
            .clk_i        (clk_i),
            .rstn_i       (rstn_i),
            .wr_i         (wr && !cfg_addr_i[4] && (cfg_addr_i[3:2] == 2'(g))),
            .reg_i        (cfg_addr_i[1:0]),
            .wdata_i      (cfg_data_i),
            .en_i         (cfg_rx_en_i[g]),
            .pending_i    (cfg_rx_pending_i[g]),
            .curr_addr_i  (cfg_rx_curr_addr_i[g*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .bytes_left_i (cfg_rx_bytes_left_i[g*TRANS_SIZE +: TRANS_SIZE]),
            .startaddr_o  (cfg_rx_startaddr_o[g*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .size_o       (cfg_rx_size_o[g*TRANS_SIZE +: TRANS_SIZE]),
            .datasize_o   (cfg_rx_datasize_o[g*2 +: 2]),
            .continuous_o (cfg_rx_continuous_o[g]),
            .en_o         (cfg_rx_en_o[g]),
            .clr_o        (cfg_rx_clr_o[g]),
            .rdata_o      (ch_rdata[g])
        );
    end

    // Copying from staging with non-blocking semantics makes active take the pre-write value on a collision
    assign ctrl_set   = wr && (cfg_addr_i == ADDR_CTRL) && cfg_data_i[CTRL_COMMIT];
    assign ctrl_force = wr && (cfg_addr_i == ADDR_CTRL) && cfg_data_i[CTRL_FORCE];
    assign do_copy    = (commit_pending && (cam_frame_start_i || !cfg_cam_ip_en_i)) || ctrl_force;

    assign status_set = {do_copy, cam_overflow_i, cam_frame_end_i, cam_frame_start_i};
    assign status_clr = (wr && (cfg_addr_i == ADDR_IRQ_STATUS)) ? cfg_data_i[3:0] : 4'h0;
    assign status_nxt = (irq_status & ~status_clr) | status_set;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stg            <= '0;
            act            <= '0;
            pol            <= '0;
            commit_pending <= 1'b0;
            irq_status     <= '0;
            irq_en         <= '0;
            irq_o          <= 1'b0;
        end else begin
            if (wr) begin
                case (cfg_addr_i)
                    ADDR_GLOB:   stg.glob   <= cfg_data_i;
                    ADDR_LL:     stg.ll     <= cfg_data_i;
                    ADDR_UR:     stg.ur     <= cfg_data_i;
                    ADDR_SIZE:   stg.size   <= cfg_data_i;
                    ADDR_FILTER: stg.filter <= cfg_data_i;
                    ADDR_POL:    pol        <= cfg_data_i[1:0];
                    ADDR_IRQ_EN: irq_en     <= cfg_data_i[3:0];
                    default: ;
                endcase
            end
            if (do_copy)
                act <= stg;
            commit_pending <= ctrl_set || (commit_pending && !do_copy);
            irq_status     <= status_nxt;
            irq_o          <= |(status_nxt & irq_en);
        end
    end

    always_comb begin
        rx_rdata = 32'h0;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_addr_i[3:2] == 2'(i))
                rx_rdata = ch_rdata[i];
    end

    always_comb begin
        cfg_data_o = 32'h0;
        case (cfg_addr_i)
            ADDR_GLOB:       cfg_data_o = {cfg_cam_ip_en_i, stg.glob[30:0]};
            ADDR_LL:         cfg_data_o = stg.ll;
            ADDR_UR:         cfg_data_o = stg.ur;
            ADDR_SIZE:       cfg_data_o = stg.size;
            ADDR_FILTER:     cfg_data_o = stg.filter;
            ADDR_POL:        cfg_data_o = {30'h0, pol};
            ADDR_CTRL:       cfg_data_o = {31'h0, commit_pending};
            ADDR_IRQ_STATUS: cfg_data_o = {28'h0, irq_status};
            ADDR_IRQ_EN:     cfg_data_o = {28'h0, irq_en};
            default:         cfg_data_o = cfg_addr_i[4] ? 32'h0 : rx_rdata;
        endcase
    end

    assign cfg_cam_cfg_o            = act.glob;
    assign cfg_cam_cfg_ll_o         = act.ll;
    assign cfg_cam_cfg_ur_o         = act.ur;
    assign cfg_cam_cfg_size_o       = act.size;
    assign cfg_cam_cfg_filter_o     = act.filter;
    assign cfg_cam_vsync_polarity_o = pol[0];
    assign cfg_cam_hsync_polarity_o = pol[1];

endmodule

// File: tb/tb_camera_reg_if_mc.sv
// tb_camera_reg_if_mc: directed self-checking bench for camera_reg_if_mc with NUM_CH=2
module tb_camera_reg_if_mc;

    localparam int AW = 12;
    localparam int TW = 16;
    localparam int NC = 2;

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b1;
    logic [31:0]    cfg_data_i = '0;
    logic [4:0]     cfg_addr_i = '0;
    logic           cfg_valid_i = 1'b0;
    logic           cfg_rwn_i = 1'b1;
    logic [31:0]    cfg_data_o;
    logic           cfg_ready_o;
    logic [NC*AW-1:0] cfg_rx_startaddr_o;
    logic [NC*TW-1:0] cfg_rx_size_o;
    logic [NC*2-1:0]  cfg_rx_datasize_o;
    logic [NC-1:0]    cfg_rx_continuous_o, cfg_rx_en_o, cfg_rx_clr_o;
    logic [NC-1:0]    cfg_rx_en_i = '0, cfg_rx_pending_i = '0;
    logic [NC*AW-1:0] cfg_rx_curr_addr_i = '0;
    logic [NC*TW-1:0] cfg_rx_bytes_left_i = '0;
    logic           cam_frame_start_i = 1'b0, cam_frame_end_i = 1'b0, cam_overflow_i = 1'b0;
    logic           cfg_cam_ip_en_i = 1'b0;
    logic [31:0]    cfg_cam_cfg_o, cfg_cam_cfg_ll_o, cfg_cam_cfg_ur_o, cfg_cam_cfg_size_o, cfg_cam_cfg_filter_o;
    logic           cfg_cam_vsync_polarity_o, cfg_cam_hsync_polarity_o, irq_o;

    int n_cmp = 0;
    int n_err = 0;

    camera_reg_if_mc #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TW), .NUM_CH(NC)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i),
        .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
        .cfg_rx_startaddr_o(cfg_rx_startaddr_o), .cfg_rx_size_o(cfg_rx_size_o),
        .cfg_rx_datasize_o(cfg_rx_datasize_o), .cfg_rx_continuous_o(cfg_rx_continuous_o),
        .cfg_rx_en_o(cfg_rx_en_o), .cfg_rx_clr_o(cfg_rx_clr_o),
        .cfg_rx_en_i(cfg_rx_en_i), .cfg_rx_pending_i(cfg_rx_pending_i),
        .cfg_rx_curr_addr_i(cfg_rx_curr_addr_i), .cfg_rx_bytes_left_i(cfg_rx_bytes_left_i),
        .cam_frame_start_i(cam_frame_start_i), .cam_frame_end_i(cam_frame_end_i),
        .cam_overflow_i(cam_overflow_i), .cfg_cam_ip_en_i(cfg_cam_ip_en_i),
        .cfg_cam_cfg_o(cfg_cam_cfg_o), .cfg_cam_cfg_ll_o(cfg_cam_cfg_ll_o),
        .cfg_cam_cfg_ur_o(cfg_cam_cfg_ur_o), .cfg_cam_cfg_size_o(cfg_cam_cfg_size_o),
        .cfg_cam_cfg_filter_o(cfg_cam_cfg_filter_o),
        .cfg_cam_vsync_polarity_o(cfg_cam_vsync_polarity_o),
        .cfg_cam_hsync_polarity_o(cfg_cam_hsync_polarity_o),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        tick();
        cfg_valid_i = 1'b0;
        cfg_rwn_i   = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = a;
        #1;
        chk(tag, cfg_data_o, exp);
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        #2 rstn_i = 1'b0;
        tick();
        tick();
        rstn_i = 1'b1;
        tick();
        chk("rst_irq", 32'(irq_o), 0);
        chk("rst_ready", 32'(cfg_ready_o), 1);
        chk("rst_saddr", 32'(cfg_rx_startaddr_o), 0);
        chk("rst_size", cfg_rx_size_o, 0);
        chk("rst_rxmisc", {cfg_rx_datasize_o, cfg_rx_continuous_o, cfg_rx_en_o, cfg_rx_clr_o}, 0);
        chk("rst_act", cfg_cam_cfg_o | cfg_cam_cfg_ll_o | cfg_cam_cfg_ur_o | cfg_cam_cfg_size_o | cfg_cam_cfg_filter_o, 0);
        chk("rst_pol", {cfg_cam_hsync_polarity_o, cfg_cam_vsync_polarity_o}, 0);
        for (int a = 0; a < 32; a++)
            rd(5'(a), 32'h0, $sformatf("rst_rd%0d", a));

        cfg_rx_curr_addr_i  = {12'hABC, 12'h000};
        cfg_rx_bytes_left_i = {16'h1234, 16'h0000};
        cfg_rx_pending_i    = 2'b10;
        cfg_rx_en_i         = 2'b10;
        rd(4, 32'h0000_0ABC, "live_saddr1");
        rd(5, 32'h0000_1234, "live_size1");
        rd(6, 32'h0000_0030, "live_cfg1");
        rd(2, 32'h0, "live_cfg0");
        cfg_cam_ip_en_i = 1'b1;
        rd(16, 32'h8000_0000, "glob_ipen");
        cfg_cam_ip_en_i = 1'b0;

        wr(4, 32'hFFFF_F123);
        chk("rx_saddr1", 32'(cfg_rx_startaddr_o), 32'h0012_3000);
        wr(5, 32'h0000_BEEF);
        chk("rx_size1", cfg_rx_size_o, 32'hBEEF_0000);
        wr(6, 32'h53);
        chk("rx_en_pulse", 32'(cfg_rx_en_o), 2'b10);
        chk("rx_clr_pulse", 32'(cfg_rx_clr_o), 2'b10);
        chk("rx_datasize", 32'(cfg_rx_datasize_o), 4'b0100);
        chk("rx_cont", 32'(cfg_rx_continuous_o), 2'b10);
        tick();
        chk("rx_en_drop", 32'(cfg_rx_en_o), 0);
        chk("rx_clr_drop", 32'(cfg_rx_clr_o), 0);
        chk("rx_datasize_hold", 32'(cfg_rx_datasize_o), 4'b0100);
        rd(6, 32'h0000_0033, "rx_cfg_rd1");
        wr(12, 32'hFFFF_FFFF);
        rd(12, 32'h0, "rx_ch3_rd");
        rd(14, 32'h0, "rx_ch3_cfg_rd");
        chk("rx_ch3_noeffect", 32'(cfg_rx_startaddr_o), 32'h0012_3000);
        wr(0, 32'h0000_0456);
        chk("rx_saddr0", 32'(cfg_rx_startaddr_o), 32'h0012_3456);

        cfg_cam_ip_en_i = 1'b1;
        wr(17, 32'h0010_0020);
        wr(22, 32'h1);
        rd(22, 32'h1, "fs_pending");
        rd(17, 32'h0010_0020, "fs_stg_ll");
        chk("fs_ll_wait0", cfg_cam_cfg_ll_o, 0);
        tick();
        tick();
        chk("fs_ll_wait1", cfg_cam_cfg_ll_o, 0);
        cam_frame_start_i = 1'b1;
        #1;
        chk("fs_ll_pre", cfg_cam_cfg_ll_o, 0);
        tick();
        cam_frame_start_i = 1'b0;
        chk("fs_ll_post", cfg_cam_cfg_ll_o, 32'h0010_0020);
        rd(22, 32'h0, "fs_ctrl_clr");
        rd(23, 32'h9, "fs_status");
        wr(23, 32'hF);
        rd(23, 32'h0, "w1c_all");

        cfg_cam_ip_en_i = 1'b0;
        wr(18, 32'h55);
        wr(22, 32'h1);
        chk("imm_ur_pre", cfg_cam_cfg_ur_o, 0);
        rd(22, 32'h1, "imm_pending");
        tick();
        chk("imm_ur_post", cfg_cam_cfg_ur_o, 32'h55);
        rd(22, 32'h0, "imm_ctrl_clr");
        cfg_cam_ip_en_i = 1'b1;
        wr(19, 32'h77);
        chk("force_size_pre", cfg_cam_cfg_size_o, 0);
        wr(22, 32'h2);
        chk("force_size_post", cfg_cam_cfg_size_o, 32'h77);
        rd(22, 32'h0, "force_ctrl");

        wr(21, 32'h3);
        chk("pol_out", {cfg_cam_hsync_polarity_o, cfg_cam_vsync_polarity_o}, 2'b11);
        rd(21, 32'h3, "pol_rd");

        wr(23, 32'hF);
        wr(24, 32'h4);
        rd(24, 32'h4, "irqen_rd");
        chk("irq_idle", 32'(irq_o), 0);
        cam_overflow_i = 1'b1;
        tick();
        cam_overflow_i = 1'b0;
        chk("irq_ovf", 32'(irq_o), 1);
        rd(23, 32'h4, "st_ovf");
        cam_overflow_i = 1'b1;
        wr(23, 32'h4);
        cam_overflow_i = 1'b0;
        rd(23, 32'h4, "st_set_wins");
        chk("irq_set_wins", 32'(irq_o), 1);
        wr(23, 32'h4);
        chk("irq_cleared", 32'(irq_o), 0);
        rd(23, 32'h0, "st_cleared");

        wr(18, 32'h66);
        wr(22, 32'h1);
        cam_frame_start_i = 1'b1;
        wr(18, 32'hAA);
        cam_frame_start_i = 1'b0;
        chk("col_ur_act", cfg_cam_cfg_ur_o, 32'h66);
        rd(18, 32'hAA, "col_ur_stg");
        rd(22, 32'h0, "col_ctrl");
        wr(22, 32'h1);
        cam_frame_start_i = 1'b1;
        wr(22, 32'h1);
        cam_frame_start_i = 1'b0;
        chk("col2_ur_act", cfg_cam_cfg_ur_o, 32'hAA);
        rd(22, 32'h1, "col2_ctrl_kept");

        rstn_i = 1'b0;
        #1;
        chk("arst_ur", cfg_cam_cfg_ur_o, 0);
        chk("arst_irq", 32'(irq_o), 0);
        rstn_i = 1'b1;
        rd(22, 32'h0, "arst_ctrl");
        wr(17, 32'h1234_5678);
        cfg_cam_ip_en_i = 1'b0;
        tick();
        tick();
        chk("arst_no_commit", cfg_cam_cfg_ll_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
